// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Drains a show-ahead synchronous FIFO into fixed-length bursts on a
// valid/ready stream with a last marker. A burst starts only once the FIFO
// holds BURST_LEN entries, so a started burst never waits for data.
// Optional macro BURST_TIMEOUT_EN: entries stranded below burst size for
// TIMEOUT_CYCLES consecutive cycles are flushed as single-beat bursts.
module fifo_burst_reader #(
    parameter int WIDTH          = 32,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             underflow_err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
`ifdef BURST_TIMEOUT_EN
    localparam logic [1:0] FLUSH = 2'd2;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    // Reject parameter values the burst and timeout logic cannot handle
    if (BURST_LEN < 2) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             slot_free;
    logic             draining;
    logic             pop;
    logic             pop_last;

`ifdef BURST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            stranded;
    logic            timeout_fire;

    assign stranded     = (state == IDLE) && !fifo_empty && fifo_almost_empty;
    assign timeout_fire = stranded && (to_cnt == TO_LAST);
`endif

    // Pop whenever the output slot can take a beat and a draining state has data
    always_comb begin
        slot_free = !m_valid || m_ready;
`ifdef BURST_TIMEOUT_EN
        draining  = (state == BURST) || (state == FLUSH);
        pop_last  = (state == FLUSH) || (beat_cnt == LAST_BEAT);
`else
        draining  = (state == BURST);
        pop_last  = (beat_cnt == LAST_BEAT);
`endif
        pop       = slot_free && !fifo_empty && draining;
    end

    assign fifo_rd_en = pop;
    assign busy       = (state != IDLE);

    // Burst sequencing, beat counting and sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            underflow_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_almost_empty) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                    end
`ifdef BURST_TIMEOUT_EN
                    else if (timeout_fire) begin
                        state <= FLUSH;
                    end
`endif
                end
                BURST: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end else if (slot_free && fifo_empty) begin
                        underflow_err <= 1'b1;
                    end
                end
`ifdef BURST_TIMEOUT_EN
                FLUSH: begin
                    if (!fifo_almost_empty || fifo_empty) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (!m_valid || (m_ready && m_last)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BURST_TIMEOUT_EN
    // Count consecutive idle cycles with stranded sub-burst data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (stranded && !timeout_fire) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`endif

    // One-entry output register; a pop refills it in the same cycle it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (pop) begin
            m_valid <= 1'b1;
            m_data  <= fifo_dout;
            m_last  <= pop_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: a behavioural show-ahead FIFO feeds the
// design, a scoreboard queue holds expected {last,data} beats in FIFO order.
module tb_fifo_burst_reader;

    localparam int WIDTH          = 32;
    localparam int BURST_LEN      = 8;
    localparam int TIMEOUT_CYCLES = 64;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_almost_empty;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic             underflow_err;

    logic [WIDTH-1:0] mem [0:255];
    logic [15:0]      wr_ptr = '0;
    logic [15:0]      rd_ptr = '0;
    logic [15:0]      fifo_count;
    logic             force_empty;
    logic             fifo_clear;
    int               rd_pulses = 0;

    logic [WIDTH:0]   exp_q [$];
    int               exp_beat_idx = 0;
    int               accepted = 0;
    int               checks = 0;
    int               failures = 0;
    logic             hold_pending = 1'b0;
    logic [WIDTH:0]   hold_val;

    fifo_burst_reader #(
        .WIDTH(WIDTH),
        .BURST_LEN(BURST_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last),
        .busy(busy),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    assign fifo_count        = wr_ptr - rd_ptr;
    assign fifo_dout         = mem[rd_ptr[7:0]];
    assign fifo_empty        = (fifo_count == 16'd0) || force_empty;
    assign fifo_almost_empty = (fifo_count <= 16'(BURST_LEN - 1));

    // FIFO model read side
    always @(posedge clk) begin
        if (fifo_clear) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            rd_ptr    <= rd_ptr + 16'd1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL beat_unexpected: got last=%0b data=%h, expected no beat", m_last, m_data);
                end else begin
                    logic [WIDTH:0] exp_beat;
                    exp_beat = exp_q.pop_front();
                    if ({m_last, m_data} !== exp_beat) begin
                        failures++;
                        $display("[TB] FAIL beat_data: got last=%0b data=%h, expected last=%0b data=%h",
                                 m_last, m_data, exp_beat[WIDTH], exp_beat[WIDTH-1:0]);
                    end
                end
                accepted++;
            end
            if (hold_pending) begin
                checks++;
                if ({m_valid, m_last, m_data} !== {1'b1, hold_val[WIDTH], hold_val[WIDTH-1:0]}) begin
                    failures++;
                    $display("[TB] FAIL hold_stable: got valid=%0b last=%0b data=%h, expected valid=1 last=%0b data=%h",
                             m_valid, m_last, m_data, hold_val[WIDTH], hold_val[WIDTH-1:0]);
                end
            end
            hold_pending = m_valid && !m_ready;
            hold_val     = {m_last, m_data};
            if (fifo_rd_en) begin
                checks++;
                if (fifo_empty) begin
                    failures++;
                    $display("[TB] FAIL pop_empty: got fifo_rd_en=1 with fifo_empty=1, expected no pop");
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input logic [WIDTH-1:0] base, input bit push, input bit flush_beats);
        logic last_bit;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = base + WIDTH'(i);
            wr_ptr = wr_ptr + 16'd1;
            if (push) begin
                last_bit = flush_beats ? 1'b1 : (exp_beat_idx == BURST_LEN - 1);
                exp_q.push_back({last_bit, base + WIDTH'(i)});
                if (!flush_beats) exp_beat_idx = (exp_beat_idx + 1) % BURST_LEN;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || m_valid || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy || m_valid || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain: got busy=%0b valid=%0b pending=%0d after %0d cycles, expected idle and 0 pending",
                     name, busy, m_valid, exp_q.size(), budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0b, expected 0", m_valid); end
        checks++; if (m_data !== '0) begin failures++; $display("[TB] FAIL reset_data: got %h, expected 0", m_data); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %0b, expected 0", m_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
        checks++; if (underflow_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_underflow: got %0b, expected 0", underflow_err); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en: got %0b, expected 0", fifo_rd_en); end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %0b, expected 0", busy); end
    endtask

    task automatic test_full_burst();
        int n;
        int pulses0;
        m_ready = 1'b1;
        pulses0 = rd_pulses;
        write_words(8, 32'h10, 1'b1, 1'b0);
        tick();
        checks++; if ({busy, fifo_rd_en, m_valid} !== 3'b110) begin failures++; $display("[TB] FAIL start_latency_1: got busy/rd_en/valid=%b, expected 110", {busy, fifo_rd_en, m_valid}); end
        tick();
        checks++; if ({m_valid, m_last, m_data} !== {2'b10, 32'h10}) begin failures++; $display("[TB] FAIL start_latency_2: got valid=%0b last=%0b data=%h, expected valid=1 last=0 data=10", m_valid, m_last, m_data); end
        n = 0;
        while (m_valid && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 8) begin failures++; $display("[TB] FAIL full_burst_valid_run: got %0d cycles, expected 8", n); end
        checks++; if (rd_pulses - pulses0 !== 8) begin failures++; $display("[TB] FAIL full_burst_pops: got %0d, expected 8", rd_pulses - pulses0); end
        wait_drain("full_burst", 50);
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        m_ready = 1'b1;
        write_words(16, 32'h100, 1'b1, 1'b0);
        n = 0;
        while (!(m_valid && m_last) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!(m_valid && m_last)) begin
            failures++;
            $display("[TB] FAIL b2b_first_last: got no last beat in 100 cycles, expected one");
        end
        tick();
        gap = 0;
        while (!m_valid && gap < 20) begin
            gap++;
            tick();
        end
        checks++; if (gap !== 2) begin failures++; $display("[TB] FAIL b2b_gap: got %0d idle cycles, expected 2", gap); end
        wait_drain("b2b", 100);
    endtask

    task automatic test_backpressure();
        int base_acc;
        int n;
        base_acc = accepted;
        m_ready  = 1'b1;
        write_words(16, 32'h200, 1'b1, 1'b0);
        n = 0;
        while ((accepted - base_acc) < 16 && n < 300) begin
            tick();
            m_ready = ~m_ready;
            n++;
        end
        m_ready = 1'b1;
        checks++; if (accepted - base_acc !== 16) begin failures++; $display("[TB] FAIL bp_beats: got %0d, expected 16", accepted - base_acc); end
        wait_drain("bp", 100);
    endtask

`ifdef BURST_TIMEOUT_EN
    task automatic test_timeout_flush();
        m_ready = 1'b1;
        write_words(3, 32'h500, 1'b1, 1'b1);
        repeat (TIMEOUT_CYCLES - 1) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got busy=%0b, expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_fire: got busy=%0b, expected 1", busy); end
        wait_drain("timeout", 50);
        checks++; if (fifo_count !== 16'd0) begin failures++; $display("[TB] FAIL timeout_fifo_empty: got count=%0d, expected 0", fifo_count); end
    endtask
`else
    task automatic test_below_threshold();
        int bad;
        m_ready = 1'b1;
        write_words(5, 32'h400, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (m_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL below_threshold: got %0d active cycles, expected 0", bad); end
        checks++; if (fifo_count !== 16'd5) begin failures++; $display("[TB] FAIL below_threshold_count: got %0d, expected 5", fifo_count); end
        fifo_clear = 1'b1;
        tick();
        fifo_clear = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        int base_acc;
        int n;
        m_ready  = 1'b1;
        base_acc = accepted;
        write_words(8, 32'h600, 1'b1, 1'b0);
        n = 0;
        while ((accepted - base_acc) < 3 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (!(m_valid && (accepted - base_acc) == 3)) begin failures++; $display("[TB] FAIL midrst_reach_beat4: got valid=%0b accepted=%0d, expected valid=1 accepted=3", m_valid, accepted - base_acc); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_last, busy, underflow_err, fifo_rd_en} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL midrst_async_clear: got valid/last/busy/uf/rd_en=%b, expected 00000",
                     {m_valid, m_last, busy, underflow_err, fifo_rd_en});
        end
        exp_q.delete();
        exp_beat_idx = 0;
        fifo_clear   = 1'b1;
        tick();
        fifo_clear = 1'b0;
        rst_n      = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle: got busy=%0b, expected 0", busy); end
        base_acc = accepted;
        write_words(8, 32'h700, 1'b1, 1'b0);
        wait_drain("midrst_restart", 60);
        checks++; if (accepted - base_acc !== 8) begin failures++; $display("[TB] FAIL midrst_restart_beats: got %0d, expected 8", accepted - base_acc); end
    endtask

    task automatic test_underflow();
        int n;
        m_ready = 1'b0;
        write_words(8, 32'h800, 1'b1, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        checks++; if (underflow_err !== 1'b0) begin failures++; $display("[TB] FAIL uf_before: got %0b, expected 0", underflow_err); end
        m_ready     = 1'b1;
        force_empty = 1'b1;
        tick();
        checks++; if (underflow_err !== 1'b1) begin failures++; $display("[TB] FAIL uf_set: got %0b, expected 1", underflow_err); end
        repeat (3) tick();
        checks++; if ({underflow_err, busy} !== 2'b11) begin failures++; $display("[TB] FAIL uf_hold: got uf/busy=%b, expected 11", {underflow_err, busy}); end
        force_empty = 1'b0;
        wait_drain("uf_resume", 60);
        checks++; if (underflow_err !== 1'b1) begin failures++; $display("[TB] FAIL uf_sticky: got %0b, expected 1", underflow_err); end
        rst_n = 1'b0;
        #2;
        checks++; if (underflow_err !== 1'b0) begin failures++; $display("[TB] FAIL uf_reset: got %0b, expected 0", underflow_err); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        fifo_clear  = 1'b0;
        test_reset();
        test_full_burst();
        test_back_to_back();
        test_backpressure();
`ifdef BURST_TIMEOUT_EN
        test_timeout_flush();
`else
        test_below_threshold();
`endif
        test_reset_mid_burst();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
